// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the MEM-stage data-port responder:
//   - access size encodings as they arrive on Bytes2Load / Bytes2Store
//   - responder FSM state encodings
//   - is_misaligned(): alignment rule shared by the load and store paths
// ---------------------------------------------------------------------------
package data_mem_pkg;

  // Size encodings. On the store side SZ_BYTEU has no meaning and is
  // handled as a full word.
  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] SZ_BYTEU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // A request is misaligned when its natural alignment is violated.
  // Encoding 2'b11 is an unsigned byte for loads but a word for stores.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo,
                                         input logic       is_store);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_WORD:  mis = (addr_lo != 2'b00);
      SZ_HALF:  mis = addr_lo[0];
      SZ_BYTE:  mis = 1'b0;
      SZ_BYTEU: mis = is_store & (addr_lo != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bundle between the EX/MEM pipeline stage (master) and the
// data-memory responder (slave).
//   MemRead, MemWrite        request strobes (held by the stage while Busy)
//   Bytes2Load, Bytes2Store  access size encodings
//   Address, WriteData       byte address and store data
//   ReadData, Busy, Done,    response: load data, stall, completion pulse,
//   Err                      error flag qualified by Done
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Bytes2Load;
  logic [1:0]  Bytes2Store;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;
  logic        Err;

  modport master (
    output MemRead, MemWrite, Bytes2Load, Bytes2Store, Address, WriteData,
    input  ReadData, Busy, Done, Err
  );

  modport slave (
    input  MemRead, MemWrite, Bytes2Load, Bytes2Store, Address, WriteData,
    output ReadData, Busy, Done, Err
  );
endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering for a little-endian 32-bit word array.
// Store side: size + addr[1:0] + wdata -> byte enables + lane-replicated data.
// Load side:  size + addr[1:0] + raw word -> extracted, extended result.
// Ports:
//   i_ld_size, i_st_size  size encodings (data_mem_pkg SZ_*)
//   i_addr_lo             byte offset within the word
//   i_wdata, i_rword      store data, raw word read from the array
//   o_be, o_wdata         store byte enables and replicated store data
//   o_rdata               extended load result
//   o_ld_misalign,        alignment violation for the load / store view
//   o_st_misalign
// ---------------------------------------------------------------------------
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ld_misalign,
  output logic        o_st_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane n of the word sits at bits [8n+7:8n]; a half uses addr[1] only.
  assign w_byte = 8'(i_rword >> {i_addr_lo, 3'b000});
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  assign o_ld_misalign = is_misaligned(i_ld_size, i_addr_lo, 1'b0);
  assign o_st_misalign = is_misaligned(i_st_size, i_addr_lo, 1'b1);

  // Store steering: replicating the data lets the enables pick the lane.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_st_size)
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load extraction and extension.
  always_comb begin
    o_rdata = i_rword;
    case (i_ld_size)
      SZ_WORD:  o_rdata = i_rword;
      SZ_HALF:  o_rdata = {{16{w_half[15]}}, w_half};
      SZ_BYTE:  o_rdata = {{24{w_byte[7]}}, w_byte};
      SZ_BYTEU: o_rdata = {24'h000000, w_byte};
      default:  o_rdata = i_rword;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the MEM-stage data port. Accepts one load/store,
// waits LATENCY cycles, performs a byte/half/word access on a word array and
// returns extended load data with a Busy stall and a one-cycle Done pulse.
// Parameters:
//   DEPTH    words in the array (power of two)
//   LATENCY  cycles spent in WAIT before the access executes (>= 1)
// Ports:
//   Clk      rising-edge clock
//   Rst      asynchronous active-low reset
//   bus      data_mem_responder_if.slave request/response bundle
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;

  // Captured request; only these are used after accept.
  logic            r_rd;
  logic            r_wr;
  logic [1:0]      r_ld;
  logic [1:0]      r_st;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;

  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_accept;
  logic            w_exec;
  logic            w_err;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_rword;
  logic [3:0]      w_be;
  logic [31:0]     w_wlanes;
  logic [31:0]     w_rdata;
  logic            w_ld_mis;
  logic            w_st_mis;
  logic            w_unused_addr_hi;

  assign w_req    = bus.MemRead | bus.MemWrite;
  assign w_accept = (r_state == ST_IDLE) & w_req;
  assign w_exec   = (r_state == ST_WAIT) & (r_cnt == {CW{1'b0}});

  // Address bits above the array size wrap around.
  assign w_unused_addr_hi = ^bus.Address[31:AW+2];
  assign w_idx   = r_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

  // A simultaneous read+write is illegal regardless of alignment.
  assign w_err = (r_rd & r_wr) | (r_rd & w_ld_mis) | (r_wr & w_st_mis);

  mem_lane_align u_align (
    .i_ld_size     (r_ld),
    .i_st_size     (r_st),
    .i_addr_lo     (r_addr[1:0]),
    .i_wdata       (r_wdata),
    .i_rword       (w_rword),
    .o_be          (w_be),
    .o_wdata       (w_wlanes),
    .o_rdata       (w_rdata),
    .o_ld_misalign (w_ld_mis),
    .o_st_misalign (w_st_mis)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; RESP always returns to IDLE so a request still
  // presented during RESP is not taken a second time.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request capture and latency counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt   <= {CW{1'b0}};
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ld    <= 2'b00;
      r_st    <= 2'b00;
      r_addr  <= {(AW+2){1'b0}};
      r_wdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_cnt   <= CNT_LOAD;
      r_rd    <= bus.MemRead;
      r_wr    <= bus.MemWrite;
      r_ld    <= bus.Bytes2Load;
      r_st    <= bus.Bytes2Store;
      r_addr  <= bus.Address[AW+1:0];
      r_wdata <= bus.WriteData;
    end else if ((r_state == ST_WAIT) && (r_cnt != {CW{1'b0}})) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Response registers: loaded on the executing edge, Err cleared after RESP.
  // Stores and errors report zero data.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (w_exec) begin
      r_err   <= w_err;
      r_rdata <= (r_rd & ~w_err) ? w_rdata : 32'h0000_0000;
    end else if (r_state == ST_RESP) begin
      r_err <= 1'b0;
    end
  end

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (w_exec & r_wr & ~w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

  assign bus.Busy     = w_accept | (r_state == ST_WAIT);
  assign bus.Done     = (r_state == ST_RESP);
  assign bus.Err      = r_err;
  assign bus.ReadData = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic Clk;
  logic Rst;
  int   errors = 0;
  int   checks = 0;

  // Byte-addressed reference image of each DUT's 4 KiB array.
  logic [7:0] ref_mem [2][4096];

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (
    .Clk (Clk), .Rst (Rst), .bus (b0)
  );
  data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .Clk (Clk), .Rst (Rst), .bus (b1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [1:0] ld, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      b0.MemRead = rd; b0.MemWrite = wr; b0.Bytes2Load = ld;
      b0.Bytes2Store = st; b0.Address = addr; b0.WriteData = wdata;
    end else begin
      b1.MemRead = rd; b1.MemWrite = wr; b1.Bytes2Load = ld;
      b1.Bytes2Store = st; b1.Address = addr; b1.WriteData = wdata;
    end
  endtask

  task automatic sample(input int sel, output logic busy, output logic done,
                        output logic err, output logic [31:0] data);
    if (sel == 0) begin
      busy = b0.Busy; done = b0.Done; err = b0.Err; data = b0.ReadData;
    end else begin
      busy = b1.Busy; done = b1.Done; err = b1.Err; data = b1.ReadData;
    end
  endtask

  // Reference behaviour: byte-granular access, aligned to the access size.
  task automatic model_access(input int sel, input logic rd, input logic wr,
                              input logic [1:0] ld, input logic [1:0] st,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] data);
    int n;
    int ba;
    logic [31:0] v;
    ba  = int'(addr[11:0]);
    err = rd & wr;
    if (rd) n = (ld == 2'd0) ? 4 : (ld == 2'd1) ? 2 : 1;
    else    n = (st == 2'd1) ? 2 : (st == 2'd2) ? 1 : 4;
    if ((ba % n) != 0) err = 1'b1;
    data = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[sel][ba + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[sel][ba + i];
        if (ld == 2'd1)      v = {{16{v[15]}}, v[15:0]};
        else if (ld == 2'd2) v = {{24{v[7]}}, v[7:0]};
        data = v;
      end
    end
  endtask

  // One transaction, called just after a rising edge. The request is held
  // through RESP and dropped on the following cycle, as a stalled stage would.
  task automatic run_op(input int sel, input logic rd, input logic wr,
                        input logic [1:0] ld, input logic [1:0] st,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_data, output logic got_err);
    int lat;
    logic exp_err, b, d, e;
    logic [31:0] exp_data, q;
    lat = (sel == 0) ? 2 : 1;
    got_data = 32'h0;
    got_err  = 1'b0;
    model_access(sel, rd, wr, ld, st, addr, wdata, exp_err, exp_data);
    drive(sel, rd, wr, ld, st, addr, wdata);
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge Clk);
      sample(sel, b, d, e, q);
      check($sformatf("busy[d%0d c%0d a=%h]", sel, c, addr), b, 32'(c <= lat));
      check($sformatf("done[d%0d c%0d a=%h]", sel, c, addr), d, 32'(c == lat + 1));
      if (c == lat + 1) begin
        got_data = q;
        got_err  = e;
        check($sformatf("err[d%0d a=%h]", sel, addr), e, exp_err);
        if (rd | exp_err) check($sformatf("rdata[d%0d a=%h]", sel, addr), q, exp_data);
      end else begin
        @(posedge Clk); #1;
      end
    end
    @(posedge Clk); #1;
    drive(sel, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge Clk);
    sample(sel, b, d, e, q);
    check($sformatf("after_busy[d%0d]", sel), b, 32'h0);
    check($sformatf("after_done[d%0d]", sel), d, 32'h0);
    check($sformatf("after_err[d%0d]", sel), e, 32'h0);
    @(posedge Clk); #1;
  endtask

  initial begin
    logic [31:0] q, ra;
    logic        e, b, d;
    int          kind;

    Rst = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, b, d, e, q);
      check($sformatf("rst_busy[d%0d]", s), b, 32'h0);
      check($sformatf("rst_done[d%0d]", s), d, 32'h0);
      check($sformatf("rst_err[d%0d]", s), e, 32'h0);
      check($sformatf("rst_rdata[d%0d]", s), q, 32'h0);
    end
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;

    // Known contents for words 0..15 of both arrays.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        run_op(s, 1'b0, 1'b1, 2'b00, 2'b00, 32'(w * 4), $urandom(), q, e);

    // Word store and reload.
    run_op(0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h10, 32'hDEADBEEF, q, e);
    run_op(0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h0, q, e);
    check("t1_lw", q, 32'hDEADBEEF);

    // Byte store, then every load width over it.
    run_op(0, 1'b0, 1'b1, 2'b00, 2'b10, 32'h13, 32'h00000080, q, e);
    run_op(0, 1'b1, 1'b0, 2'b10, 2'b00, 32'h13, 32'h0, q, e);
    check("t2_lb", q, 32'hFFFFFF80);
    run_op(0, 1'b1, 1'b0, 2'b11, 2'b00, 32'h13, 32'h0, q, e);
    check("t2_lbu", q, 32'h00000080);
    run_op(0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h0, q, e);
    check("t2_lw", q, 32'h80ADBEEF);
    run_op(0, 1'b1, 1'b0, 2'b01, 2'b00, 32'h12, 32'h0, q, e);
    check("t2_lh", q, 32'hFFFF80AD);

    // Illegal requests leave the array untouched.
    run_op(0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h11, 32'h0, q, e);
    check("t3_lw_mis_err", e, 32'h1);
    run_op(0, 1'b0, 1'b1, 2'b00, 2'b01, 32'h13, 32'hFFFFFFFF, q, e);
    check("t3_sh_mis_err", e, 32'h1);
    run_op(0, 1'b1, 1'b1, 2'b00, 2'b00, 32'h10, 32'h11111111, q, e);
    check("t3_rdwr_err", e, 32'h1);
    check("t3_rdwr_data", q, 32'h0);
    run_op(0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h0, q, e);
    check("t3_lw_after", q, 32'h80ADBEEF);

    // Reset in WAIT: no commit, outputs cleared at once.
    run_op(0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h20, 32'h0BADF00D, q, e);
    run_op(0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h20, 32'h0, q, e);
    check("t4_pre_lw", q, 32'h0BADF00D);
    drive(0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h20, 32'h12345678);
    @(negedge Clk);
    sample(0, b, d, e, q);
    check("t4_busy_c0", b, 32'h1);
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    #1;
    sample(0, b, d, e, q);
    check("t4_rst_busy", b, 32'h0);
    check("t4_rst_done", d, 32'h0);
    check("t4_rst_rdata", q, 32'h0);
    check("t4_rst_err", e, 32'h0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    run_op(0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h20, 32'h0, q, e);
    check("t4_lw_prior", q, 32'h0BADF00D);

    // Wrap-around on both latencies.
    for (int s = 0; s < 2; s++) begin
      run_op(s, 1'b0, 1'b1, 2'b00, 2'b00, 32'h1000, 32'hA5A5A5A5, q, e);
      run_op(s, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0000, 32'h0, q, e);
      check($sformatf("t6_wrap[d%0d]", s), q, 32'hA5A5A5A5);
    end

    // Random mix over words 0..15 with random upper address bits.
    for (int i = 0; i < 80; i++) begin
      ra   = $urandom();
      ra   = (ra & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      kind = int'($urandom_range(0, 9));
      run_op(i % 2, (kind == 0) || (kind >= 5), (kind <= 4),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ra, $urandom(), q, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
